// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: fixed-time two-way intersection controller with all-red clearance
module traffic_light_ctrl #(
  parameter int GREEN_CYCLES  = 20,
  parameter int YELLOW_CYCLES = 5,
  parameter int ALLRED_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] light_NS,
  output logic [2:0] light_EW
);
  localparam int MAX_D = (GREEN_CYCLES > YELLOW_CYCLES)
                         ? ((GREEN_CYCLES > ALLRED_CYCLES) ? GREEN_CYCLES : ALLRED_CYCLES)
                         : ((YELLOW_CYCLES > ALLRED_CYCLES) ? YELLOW_CYCLES : ALLRED_CYCLES);
  localparam int CW = (MAX_D > 1) ? $clog2(MAX_D) : 1;
  localparam logic [CW-1:0] G_L = CW'(GREEN_CYCLES - 1);
  localparam logic [CW-1:0] Y_L = CW'(YELLOW_CYCLES - 1);
  localparam logic [CW-1:0] A_L = CW'(ALLRED_CYCLES - 1);
  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;
  typedef enum logic [2:0] {
    S_NS_GREEN, S_NS_YELLOW, S_ALLRED_1, S_EW_GREEN, S_EW_YELLOW, S_ALLRED_2
  } state_t;
  state_t        state_q, state_d, nxt;
  logic [CW-1:0] cnt_q, cnt_d, lim;
  logic [2:0]    light_ns_q, light_ns_d, light_ew_q, light_ew_d;
  logic          bad, done;
  always_comb begin
    nxt = S_NS_GREEN;
    lim = '0;
    bad = 1'b0;
    case (state_q)
      S_NS_GREEN:  begin nxt = S_NS_YELLOW; lim = G_L; end
      S_NS_YELLOW: begin nxt = S_ALLRED_1;  lim = Y_L; end
      S_ALLRED_1:  begin nxt = S_EW_GREEN;  lim = A_L; end
      S_EW_GREEN:  begin nxt = S_EW_YELLOW; lim = G_L; end
      S_EW_YELLOW: begin nxt = S_ALLRED_2;  lim = Y_L; end
      S_ALLRED_2:  begin nxt = S_NS_GREEN;  lim = A_L; end
      default:     bad = 1'b1;
    endcase
    done       = bad || (cnt_q == lim);
    state_d    = done ? nxt : state_q;
    cnt_d      = done ? '0 : cnt_q + CW'(1);
    light_ns_d = (state_d == S_NS_GREEN) ? GRN : (state_d == S_NS_YELLOW) ? YEL : RED;
    light_ew_d = (state_d == S_EW_GREEN) ? GRN : (state_d == S_EW_YELLOW) ? YEL : RED;
  end
  // lamps are registered alongside the state so they never glitch on decode
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_NS_GREEN;
      cnt_q      <= '0;
      light_ns_q <= GRN;
      light_ew_q <= RED;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      light_ns_q <= light_ns_d;
      light_ew_q <= light_ew_d;
    end
  end
  assign light_NS = light_ns_q;
  assign light_EW = light_ew_q;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed check of lamp timing, reset behaviour and safety invariants
module tb_traffic_light_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] light_NS, light_EW, fast_ns, fast_ew;
  int         errors = 0;
  int         checks = 0;
  int         p = 0;
  traffic_light_ctrl dut (
    .clk(clk), .reset(reset), .light_NS(light_NS), .light_EW(light_EW)
  );
  traffic_light_ctrl #(.GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALLRED_CYCLES(1)) dut_fast (
    .clk(clk), .reset(reset), .light_NS(fast_ns), .light_EW(fast_ew)
  );
  always #5 clk = ~clk;
  function automatic logic [5:0] exp_lamps(int pos, int g, int y, int a);
    int q;
    q = pos % (2 * (g + y + a));
    if (q < g) return {3'b001, 3'b100};
    q -= g;
    if (q < y) return {3'b010, 3'b100};
    q -= y;
    if (q < a) return {3'b100, 3'b100};
    q -= a;
    if (q < g) return {3'b100, 3'b001};
    q -= g;
    if (q < y) return {3'b100, 3'b010};
    return {3'b100, 3'b100};
  endfunction
  function automatic logic safe(logic [2:0] ns, logic [2:0] ew);
    return $onehot(ns) && $onehot(ew) && (ns == 3'b100 || ew == 3'b100);
  endfunction
  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s p=%0d t=%0t got=%b exp=%b", tag, p, $time, got, exp);
    end
  endtask
  // drive reset for the coming edge, then sample at the following falling edge
  task automatic step(input logic rst);
    logic [5:0] e, f;
    reset = rst;
    @(negedge clk);
    p = rst ? 0 : p + 1;
    e = exp_lamps(p, 20, 5, 2);
    f = exp_lamps(p, 1, 1, 1);
    chk("lamps", {light_NS, light_EW}, e);
    chk("safe", {5'd0, safe(light_NS, light_EW)}, 6'd1);
    chk("fast_lamps", {fast_ns, fast_ew}, f);
    chk("fast_safe", {5'd0, safe(fast_ns, fast_ew)}, 6'd1);
  endtask
  initial begin
    for (int i = 0; i < 6; i++) step(1'b1);
    for (int i = 0; i < 120; i++) step(1'b0);
    for (int i = 0; i < 54 && (p % 54) != 30; i++) step(1'b0);
    chk("mid_ew_green", {light_NS, light_EW}, {3'b100, 3'b001});
    step(1'b1);
    chk("mid_reset", {light_NS, light_EW}, {3'b001, 3'b100});
    for (int i = 0; i < 70; i++) step(1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
